// File: rtl/bsg_fifo_rolly_wr_pkt_ctrl.sv
// Write-side packet sequencer for the rolly FIFO tracker: enqueue, commit/drop, overflow sink.
// Optional decision timeout enabled by defining BSG_ROLLY_WR_PKT_CTRL_TIMEOUT_EN.
module bsg_fifo_rolly_wr_pkt_ctrl #(
   parameter int lg_size_p   = 3,
   parameter int max_beats_p = (1 << lg_size_p),
   parameter int timeout_p   = 256
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 v_i,
   input  logic                 last_i,
   output logic                 ready_o,
   input  logic                 decide_v_i,
   input  logic                 decide_commit_i,
   output logic                 decide_ready_o,
   input  logic                 clear_i,
   input  logic                 full_i,
   output logic                 w_enq_o,
   output logic                 w_forward_o,
   output logic                 w_rewind_o,
   output logic                 w_clear_o,
   output logic                 w_incr_o,
   output logic [lg_size_p:0]   pkt_len_o,
   output logic                 committed_o,
   output logic                 dropped_o,
   output logic                 overflow_o,
   output logic                 timeout_o
);

   localparam int lw_lp = lg_size_p + 1;
   localparam logic [lg_size_p:0] max_lp = lw_lp'(max_beats_p);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      DECIDE = 2'd2,
      DRAIN  = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [lg_size_p:0] len_q, len_d;
   logic               beat, dec, to_hit;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
      end
   end

`ifdef BSG_ROLLY_WR_PKT_CTRL_TIMEOUT_EN
   localparam int cw_lp = $clog2(timeout_p + 1);
   localparam logic [cw_lp-1:0] to_lp = cw_lp'(timeout_p);

   logic [cw_lp-1:0] cnt_q, cnt_d;

   // Count only cycles spent waiting in DECIDE; restart on every entry.
   always_comb begin
      cnt_d = cnt_q;
      if (state_d == DECIDE && state_q != DECIDE)
         cnt_d = '0;
      else if (state_q == DECIDE && !decide_v_i && cnt_q != to_lp)
         cnt_d = cnt_q + cw_lp'(1);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign to_hit = (cnt_q == to_lp);
`else
   assign to_hit = 1'b0;
`endif

   assign w_incr_o  = 1'b0;
   assign pkt_len_o = len_q;

   always_comb begin
      ready_o        = 1'b0;
      decide_ready_o = 1'b0;
      w_enq_o        = 1'b0;
      w_forward_o    = 1'b0;
      w_rewind_o     = 1'b0;
      w_clear_o      = 1'b0;
      committed_o    = 1'b0;
      dropped_o      = 1'b0;
      overflow_o     = 1'b0;
      timeout_o      = 1'b0;
      beat           = 1'b0;
      dec            = 1'b0;
      state_d        = state_q;
      len_d          = len_q;
      if (reset_i) begin
         state_d = IDLE;
         len_d   = '0;
      end else if (clear_i) begin
         w_clear_o = 1'b1;
         state_d   = IDLE;
         len_d     = '0;
      end else begin
         unique case (state_q)
            IDLE, FILL: begin
               ready_o        = ~full_i;
               beat           = v_i & ready_o;
               decide_ready_o = beat & last_i;
               dec            = decide_v_i & decide_ready_o;
               if (beat) begin
                  // A packet longer than the FIFO can never commit; drop it now.
                  if (len_q == max_lp) begin
                     w_rewind_o = 1'b1;
                     overflow_o = 1'b1;
                     dropped_o  = 1'b1;
                     len_d      = '0;
                     state_d    = last_i ? IDLE : DRAIN;
                  end else if (dec && decide_commit_i) begin
                     w_enq_o     = 1'b1;
                     w_forward_o = 1'b1;
                     committed_o = 1'b1;
                     len_d       = '0;
                     state_d     = IDLE;
                  end else if (dec) begin
                     w_rewind_o = 1'b1;
                     dropped_o  = 1'b1;
                     len_d      = '0;
                     state_d    = IDLE;
                  end else begin
                     w_enq_o = 1'b1;
                     len_d   = len_q + lw_lp'(1);
                     state_d = last_i ? DECIDE : FILL;
                  end
               end
            end
            DECIDE: begin
               decide_ready_o = 1'b1;
               dec            = decide_v_i;
               if (dec && decide_commit_i) begin
                  w_forward_o = 1'b1;
                  committed_o = 1'b1;
                  len_d       = '0;
                  state_d     = IDLE;
               end else if (dec || to_hit) begin
                  w_rewind_o = 1'b1;
                  dropped_o  = 1'b1;
                  timeout_o  = ~dec;
                  len_d      = '0;
                  state_d    = IDLE;
               end
            end
            DRAIN: begin
               ready_o = 1'b1;
               beat    = v_i;
               if (beat && last_i) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bsg_fifo_rolly_wr_pkt_ctrl.sv
// Scoreboard bench for bsg_fifo_rolly_wr_pkt_ctrl (lg_size_p=3, max_beats_p=4, timeout_p=5).
module tb_bsg_fifo_rolly_wr_pkt_ctrl;

   logic       clk_i = 1'b0;
   logic       reset_i, v_i, last_i, decide_v_i, decide_commit_i;
   logic       clear_i, full_i;
   logic       ready_o, decide_ready_o, w_enq_o, w_forward_o, w_rewind_o;
   logic       w_clear_o, w_incr_o, committed_o, dropped_o, overflow_o, timeout_o;
   logic [3:0] pkt_len_o;

   localparam logic [10:0] R = 11'h400;
   localparam logic [10:0] D = 11'h200;
   localparam logic [10:0] E = 11'h100;
   localparam logic [10:0] F = 11'h080;
   localparam logic [10:0] W = 11'h040;
   localparam logic [10:0] C = 11'h020;
   localparam logic [10:0] M = 11'h008;
   localparam logic [10:0] X = 11'h004;
   localparam logic [10:0] O = 11'h002;
   localparam logic [10:0] T = 11'h001;

   typedef struct packed {
      logic [10:0] o;
      logic [3:0]  l;
   } exp_t;

   exp_t  exp_q[$];
   string tag_q[$];
   int    n_chk = 0;
   int    n_err = 0;

   bsg_fifo_rolly_wr_pkt_ctrl #(
      .lg_size_p  (3),
      .max_beats_p(4),
      .timeout_p  (5)
   ) dut (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .v_i            (v_i),
      .last_i         (last_i),
      .ready_o        (ready_o),
      .decide_v_i     (decide_v_i),
      .decide_commit_i(decide_commit_i),
      .decide_ready_o (decide_ready_o),
      .clear_i        (clear_i),
      .full_i         (full_i),
      .w_enq_o        (w_enq_o),
      .w_forward_o    (w_forward_o),
      .w_rewind_o     (w_rewind_o),
      .w_clear_o      (w_clear_o),
      .w_incr_o       (w_incr_o),
      .pkt_len_o      (pkt_len_o),
      .committed_o    (committed_o),
      .dropped_o      (dropped_o),
      .overflow_o     (overflow_o),
      .timeout_o      (timeout_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 2 time units later.
   task automatic step(input string tag, input logic rst, input logic v, input logic last,
                       input logic dv, input logic dc, input logic clr, input logic full,
                       input logic [10:0] eo, input logic [3:0] el);
      exp_t e;
      @(negedge clk_i);
      reset_i         = rst;
      v_i             = v;
      last_i          = last;
      decide_v_i      = dv;
      decide_commit_i = dc;
      clear_i         = clr;
      full_i          = full;
      e.o = eo;
      e.l = el;
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   always @(negedge clk_i) begin
      exp_t  e;
      string t;
      #2;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         chk({t, "_out"},
             {21'd0, ready_o, decide_ready_o, w_enq_o, w_forward_o, w_rewind_o,
              w_clear_o, w_incr_o, committed_o, dropped_o, overflow_o, timeout_o},
             {21'd0, e.o});
         chk({t, "_len"}, {28'd0, pkt_len_o}, {28'd0, e.l});
      end
   end

   initial begin
      reset_i = 1'b1; v_i = 1'b0; last_i = 1'b0; decide_v_i = 1'b0;
      decide_commit_i = 1'b0; clear_i = 1'b0; full_i = 1'b0;

      step("rst0", 1, 0, 0, 0, 0, 0, 0, 0, 0);
      step("rst1", 1, 1, 1, 1, 1, 0, 0, 0, 0);

      // 3-beat packet, commit two cycles after the last beat
      step("p3_b1", 0, 1, 0, 0, 0, 0, 0, R|E, 0);
      step("p3_b2", 0, 1, 0, 0, 0, 0, 0, R|E, 1);
      step("p3_b3", 0, 1, 1, 0, 0, 0, 0, R|D|E, 2);
      step("p3_wait", 0, 0, 0, 0, 0, 0, 0, D, 3);
      step("p3_commit", 0, 0, 0, 1, 1, 0, 0, D|F|M, 3);
      step("p3_idle", 0, 0, 0, 0, 0, 0, 0, R, 0);

      // decision without a beat outside DECIDE is ignored
      step("ign_dec", 0, 0, 0, 1, 1, 0, 0, R, 0);

      // 1-beat packet dropped in the same cycle
      step("p1_drop", 0, 1, 1, 1, 0, 0, 0, R|D|W|X, 0);
      step("p1_idle", 0, 0, 0, 0, 0, 0, 0, R, 0);

      // 6-beat packet with max 4: overflow on beat 5, beat 6 sunk
      step("ov_b1", 0, 1, 0, 0, 0, 0, 0, R|E, 0);
      step("ov_b2", 0, 1, 0, 0, 0, 0, 0, R|E, 1);
      step("ov_b3", 0, 1, 0, 0, 0, 0, 0, R|E, 2);
      step("ov_b4", 0, 1, 0, 0, 0, 0, 0, R|E, 3);
      step("ov_b5", 0, 1, 0, 0, 0, 0, 0, R|W|O|X, 4);
      step("ov_b6", 0, 1, 1, 0, 0, 0, 0, R, 0);
      step("ov_next", 0, 1, 1, 1, 1, 0, 0, R|D|E|F|M, 0);
      step("ov_idle", 0, 0, 0, 0, 0, 0, 0, R, 0);

      // full stalls mid-packet, length held
      step("fu_b1", 0, 1, 0, 0, 0, 0, 0, R|E, 0);
      step("fu_st1", 0, 1, 0, 0, 0, 0, 1, 0, 1);
      step("fu_st2", 0, 1, 1, 1, 1, 0, 1, 0, 1);
      step("fu_b2", 0, 1, 0, 0, 0, 0, 0, R|E, 1);
      step("fu_b3", 0, 1, 1, 0, 0, 0, 0, R|D|E, 2);
      step("fu_drop", 0, 1, 0, 1, 0, 0, 0, D|W|X, 3);
      step("fu_idle", 0, 0, 0, 0, 0, 0, 0, R, 0);

      // clear in DECIDE beats a pending commit
      step("cl_b1", 0, 1, 1, 0, 0, 0, 0, R|D|E, 0);
      step("cl_dec", 0, 1, 0, 1, 1, 1, 0, C, 1);
      step("cl_idle", 0, 0, 0, 0, 0, 0, 0, R, 0);

      // clear in FILL with a beat offered
      step("cf_b1", 0, 1, 0, 0, 0, 0, 0, R|E, 0);
      step("cf_clr", 0, 1, 1, 1, 1, 1, 0, C, 1);
      step("cf_idle", 0, 0, 0, 0, 0, 0, 0, R, 0);

      // long wait in DECIDE
      step("to_b1", 0, 1, 1, 0, 0, 0, 0, R|D|E, 0);
      for (int i = 0; i < 100; i++) begin
`ifdef BSG_ROLLY_WR_PKT_CTRL_TIMEOUT_EN
         if (i < 5)       step("to_wait", 0, 0, 0, 0, 0, 0, 0, D, 1);
         else if (i == 5) step("to_fire", 0, 0, 0, 0, 0, 0, 0, D|W|X|T, 1);
         else             step("to_idle", 0, 0, 0, 0, 0, 0, 0, R, 0);
`else
         step("to_wait", 0, 0, 0, 0, 0, 0, 0, D, 1);
`endif
      end
`ifdef BSG_ROLLY_WR_PKT_CTRL_TIMEOUT_EN
      step("to_end", 0, 0, 0, 1, 1, 0, 0, R, 0);
`else
      step("to_end", 0, 0, 0, 1, 1, 0, 0, D|F|M, 1);
`endif
      step("fin", 0, 0, 0, 0, 0, 0, 0, R, 0);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk_i);
      #5;
      chk("sb_drain", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
